// File: rtl/byte_splitter_pkg.sv
// Shared constants and types for the byte-to-symbol splitter.
package byte_splitter_pkg;

    localparam int DEF_BYTE_W      = 8;
    localparam int DEF_SYM_W       = 2;
    localparam int SYMS_PER_BYTE   = DEF_BYTE_W / DEF_SYM_W;

    // Symbol counter width; never below one bit so the counter always exists.
    function automatic int cnt_width(input int syms);
        return (syms > 1) ? $clog2(syms) : 1;
    endfunction

    localparam int CNT_W = cnt_width(SYMS_PER_BYTE);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO, first-word fall-through read, wrap-bit pointers.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags from pointer comparison; wrap bit separates full from empty.
    always_comb begin
        empty     = (wr_ptr_r == rd_ptr_r);
        full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        rdata     = mem_r[rd_ptr_r[AW-1:0]];
    end

    // Pointer update; overflow/underflow requests are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/byte_splitter.sv
// Buffers bytes and serialises each one MSB-pair first as one unbroken
// dout_en burst so the downstream symbol counter stays byte-aligned.
module byte_splitter
    import byte_splitter_pkg::*;
#(
    parameter int BYTE_W     = DEF_BYTE_W,
    parameter int SYM_W      = DEF_SYM_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic [SYM_W-1:0]  dout,
    output logic              dout_en,
    output logic              busy
);

    localparam int            SPB      = BYTE_W / SYM_W;
    localparam int            CW       = cnt_width(SPB);
    localparam logic [CW-1:0] LAST_CNT = CW'(SPB - 1);

    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [BYTE_W-1:0] fifo_rdata_s;
    logic              push_s;
    logic              pop_s;
    logic              burst_end_s;

    state_t            state_r;
    logic [CW-1:0]     sym_cnt_r;
    logic [BYTE_W-1:0] shift_r;
    logic [SYM_W-1:0]  dout_r;
    logic              dout_en_r;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (din),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Handshake and pop decisions; a full FIFO never accepts, even while popping.
    always_comb begin
        din_rdy     = !fifo_full_s;
        push_s      = din_vld && !fifo_full_s;
        burst_end_s = (state_r == SHIFT) && (sym_cnt_r == LAST_CNT);
        pop_s       = !fifo_empty_s && ((state_r == IDLE) || burst_end_s);
        busy        = !fifo_empty_s || (state_r == SHIFT) || dout_en_r;
        dout        = dout_r;
        dout_en     = dout_en_r;
    end

    // Serialiser FSM: loads a byte, shifts out one symbol per cycle, and
    // reloads at the terminal count so consecutive bursts have no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            sym_cnt_r <= {CW{1'b0}};
            shift_r   <= {BYTE_W{1'b0}};
            dout_r    <= {SYM_W{1'b0}};
            dout_en_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    dout_en_r <= 1'b0;
                    if (pop_s) begin
                        shift_r   <= fifo_rdata_s;
                        sym_cnt_r <= {CW{1'b0}};
                        state_r   <= SHIFT;
                    end
                end
                SHIFT: begin
                    dout_r    <= shift_r[BYTE_W-1 -: SYM_W];
                    dout_en_r <= 1'b1;
                    sym_cnt_r <= sym_cnt_r + CW'(1);
                    if (burst_end_s && pop_s) begin
                        shift_r <= fifo_rdata_s;
                    end else begin
                        shift_r <= shift_r << SYM_W;
                        if (burst_end_s) begin
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    dout_en_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
